uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver; pairs with the team's UART transmitter on the opposite end of the link.
- Samples the asynchronous rx line using an oversampling tick enable from the shared baud generator.
- Frame format: 1 start bit, DATA_BITS data bits LSB first, optional parity bit, 1 stop bit.
- Delivers each byte with a one-cycle valid strobe and reports framing and parity errors.

Parameters:
OVERSAMPLE, 16, ticks per bit period; even, >=4
DATA_BITS, 8, data bits per frame; 5..8

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
baud_tick_en  input  1  single-cycle oversampling enable, OVERSAMPLE pulses per bit period
rx_in  input  1  asynchronous serial line, idle high
rx_data  output  DATA_BITS  last correctly received word
rx_data_valid  output  1  one-cycle strobe, rx_data updated
rx_frame_err  output  1  one-cycle strobe, stop bit sampled low
rx_parity_err  output  1  one-cycle strobe, parity mismatch (0 when feature compiled out)
rx_busy  output  1  high in any state other than IDLE

Behaviour:
- Interface decision: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: rx_data=0, rx_data_valid=0, rx_frame_err=0, rx_parity_err=0, rx_busy=0, state=IDLE.
- Reset also sets: synchronizer flops=1, armed=1.
- rx_in passes through a 2-flop synchronizer (rx_sync) before any use.
- All state and counter advances occur only on cycles with baud_tick_en=1.
- States: IDLE, START, DATA, PARITY (feature only), STOP.
- IDLE:
  - If armed=0, set armed=1 on any tick where rx_sync=1.
  - If armed=1 and rx_sync=0 on a tick, go to START and clear the tick counter. This tick is the detection tick.
- START:
  - Sample on the OVERSAMPLE/2-th tick after detection (mid start bit).
  - rx_sync=0: go to DATA, clear tick counter and bit index.
  - rx_sync=1: glitch; return to IDLE with no strobe.
- DATA:
  - Sample every OVERSAMPLE ticks. Shift the sample in at bit index (LSB first) into an internal shift register. rx_data is not touched.
  - After DATA_BITS samples, go to PARITY (feature) or STOP.
- STOP:
  - Sample after OVERSAMPLE ticks.
  - rx_sync=1 and no parity error: load rx_data from the shift register and pulse rx_data_valid.
  - rx_sync=0: pulse rx_frame_err, hold rx_data, clear armed.
  - Parity error with good stop: pulse rx_parity_err only; rx_data is not updated.
  - In all cases return to IDLE on the same edge, at mid stop bit, so back-to-back frames are caught.
- Latency:
  - The stop sample is on tick OVERSAMPLE/2 + OVERSAMPLE*(DATA_BITS+1) after detection (152 for defaults; add OVERSAMPLE with parity).
  - Strobes are registered on that clock edge.
- Strobes last exactly one clk cycle and are never simultaneous with each other.
- armed=0 after a framing error means a held-low line (break) produces exactly one error, not repeated frames.
- Tick counter width is clog2(OVERSAMPLE); bit index is 4 bits. Both wrap by explicit clear, never by overflow.
- rst asserted mid-frame aborts immediately to reset values. No strobe fires after rst deassertion until a full new frame is received.

Optional Feature:
- Macro: UART_RX_PARITY_EN
- Defined:
  - PARITY state inserted after DATA.
  - Parity bit sampled OVERSAMPLE ticks after the last data bit; even parity required (XOR of data and parity bit = 0).
  - Result is evaluated at the stop sample as described above.
- Undefined:
  - No PARITY state; frame goes DATA to STOP.
  - rx_parity_err tied to 0.

Test Plan:
- Frame 0xA5 on rx_in at 16 ticks/bit -> single rx_data_valid pulse, rx_data=0xA5, 152 ticks after detection; rx_frame_err=0.
- rx_in low for 4 ticks then high -> returns to IDLE, no strobes, rx_busy drops, rx_data unchanged.
- Frame 0x3C with stop bit driven 0, preceded by a good 0x11 -> rx_frame_err pulse, rx_data stays 0x11.
- Line then held low 40 bit-times -> no further strobes until the line returns high and a new frame arrives.
- Back-to-back 0x00 then 0xFF with no idle gap -> two valid pulses, data 0x00 then 0xFF.
- rst pulsed during bit 3 of 0x5A, then frame 0x81 -> no strobe for 0x5A, valid with 0x81.
- UART_RX_PARITY_EN defined: 0x07 with parity 1 -> valid; 0x07 with parity 0 -> rx_parity_err only, rx_data unchanged.

Source files
------------

// File: rtl/uart_receiver.sv
// UART receiver: oversampled start/data/stop framing with a one-cycle strobe per frame.
// Build with UART_RX_PARITY_EN defined to add an even-parity bit between the data bits and the stop bit.
module uart_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick_en,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [3:0]       BIT_LAST  = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 armed_q, armed_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q, perr_d;
  logic                 par_bad_q, par_bad_d;
`endif

  logic rx_sync;
  assign rx_sync = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= 2'b11;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      armed_q   <= 1'b1;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      sync_q    <= {sync_q[0], rx_in};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      armed_q   <= armed_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    data_d    = data_q;
    armed_d   = armed_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif
    if (baud_tick_en) begin
      case (state_q)
        IDLE: begin
          // After a framing error the line must go high once before a new start is accepted.
          if (!armed_q) begin
            if (rx_sync) armed_d = 1'b1;
          end else if (!rx_sync) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = rx_sync ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == FULL_LAST) begin
            cnt_d = '0;
            for (int i = 0; i < DATA_BITS; i++) begin
              if (bit_q == 4'(i)) shift_d[i] = rx_sync;
            end
            if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == FULL_LAST) begin
            cnt_d     = '0;
            par_bad_d = (^shift_q) ^ rx_sync;
            state_d   = STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        STOP: begin
          // Leaving at mid stop bit leaves half a bit to catch an immediately following start.
          if (cnt_q == FULL_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
            if (!rx_sync) begin
              ferr_d  = 1'b1;
              armed_d = 1'b0;
            end
`ifdef UART_RX_PARITY_EN
            else if (par_bad_q) begin
              perr_d = 1'b1;
            end
`endif
            else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rx_data       = data_q;
  assign rx_data_valid = valid_q;
  assign rx_frame_err  = ferr_q;
  assign rx_busy       = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = perr_q;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: tick-aligned serial frames, strobe monitor, per-scenario inline checks.
module tb_uart_receiver;

  localparam int OS           = 16;
  localparam int DB           = 8;
  localparam int CLK_PER_TICK = 4;
`ifdef UART_RX_PARITY_EN
  localparam int EXP_LAT = 168;
`else
  localparam int EXP_LAT = 152;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          baud_tick_en = 1'b0;
  logic          rx_in = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_data_valid;
  logic          rx_frame_err;
  logic          rx_parity_err;
  logic          rx_busy;

  uart_receiver #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk           (clk),
    .rst           (rst),
    .baud_tick_en  (baud_tick_en),
    .rx_in         (rx_in),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .rx_busy       (rx_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int tick_num = 0;
  int t0       = 0;

  int            n_valid = 0;
  int            n_ferr  = 0;
  int            n_perr  = 0;
  int            last_valid_tick = 0;
  logic [DB-1:0] rx_q[$];
  bit            simul = 1'b0;

  // Tick generator: tick_num is the index of the tick seen at the next tick edge.
  initial begin : tickgen
    int div;
    div = 0;
    forever begin
      @(negedge clk);
      baud_tick_en = (div == 0);
      if (div == 0) tick_num++;
      div = (div + 1) % CLK_PER_TICK;
    end
  end

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (rx_data_valid === 1'b1) begin
        n_valid++;
        last_valid_tick = tick_num;
        rx_q.push_back(rx_data);
      end
      if (rx_frame_err === 1'b1) n_ferr++;
      if (rx_parity_err === 1'b1) n_perr++;
      if ((rx_data_valid && rx_frame_err) || (rx_data_valid && rx_parity_err) ||
          (rx_frame_err && rx_parity_err)) simul = 1'b1;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do begin
        @(posedge clk);
      end while (baud_tick_en !== 1'b1);
    end
    @(negedge clk);
  endtask

  task automatic align_tick();
    wait_ticks(1);
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    wait_ticks(OS);
  endtask

  // Caller must be at the negedge right after a tick; detection lands on tick t0+1.
  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    t0 = tick_num;
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop_b);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (rx_data !== 8'h00) $display("FAIL rst_data: got %h want 00", rx_data); else n_pass++;
    n_checks++; if (rx_data_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", rx_data_valid); else n_pass++;
    n_checks++; if (rx_frame_err !== 1'b0) $display("FAIL rst_ferr: got %b want 0", rx_frame_err); else n_pass++;
    n_checks++; if (rx_parity_err !== 1'b0) $display("FAIL rst_perr: got %b want 0", rx_parity_err); else n_pass++;
    n_checks++; if (rx_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", rx_busy); else n_pass++;
    rst = 1'b0;
    wait_ticks(4);
  endtask

  task automatic test_frame_a5();
    int v0, f0;
    align_tick();
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'hA5, 1'b1);
    rx_in = 1'b1;
    wait_ticks(4);
    n_checks++; if (n_valid - v0 !== 1) $display("FAIL a5_pulses: got %0d want 1", n_valid - v0); else n_pass++;
    n_checks++; if (rx_data !== 8'hA5) $display("FAIL a5_data: got %h want a5", rx_data); else n_pass++;
    n_checks++; if (last_valid_tick - (t0 + 1) !== EXP_LAT)
      $display("FAIL a5_latency: got %0d want %0d", last_valid_tick - (t0 + 1), EXP_LAT); else n_pass++;
    n_checks++; if (n_ferr - f0 !== 0) $display("FAIL a5_ferr: got %0d want 0", n_ferr - f0); else n_pass++;
    n_checks++; if (rx_busy !== 1'b0) $display("FAIL a5_busy_idle: got %b want 0", rx_busy); else n_pass++;
  endtask

  task automatic test_glitch();
    int v0, f0;
    align_tick();
    v0 = n_valid; f0 = n_ferr;
    rx_in = 1'b0;
    wait_ticks(2);
    n_checks++; if (rx_busy !== 1'b1) $display("FAIL glitch_busy_hi: got %b want 1", rx_busy); else n_pass++;
    wait_ticks(2);
    rx_in = 1'b1;
    wait_ticks(OS);
    n_checks++; if (rx_busy !== 1'b0) $display("FAIL glitch_busy_lo: got %b want 0", rx_busy); else n_pass++;
    n_checks++; if (n_valid - v0 !== 0) $display("FAIL glitch_valid: got %0d want 0", n_valid - v0); else n_pass++;
    n_checks++; if (n_ferr - f0 !== 0) $display("FAIL glitch_ferr: got %0d want 0", n_ferr - f0); else n_pass++;
    n_checks++; if (rx_data !== 8'hA5) $display("FAIL glitch_data: got %h want a5", rx_data); else n_pass++;
  endtask

  task automatic test_frame_err_break();
    int v0, f0;
    align_tick();
    send_frame(8'h11, 1'b1);
    n_checks++; if (rx_data !== 8'h11) $display("FAIL ferr_pre_data: got %h want 11", rx_data); else n_pass++;
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h3C, 1'b0);
    n_checks++; if (n_ferr - f0 !== 1) $display("FAIL ferr_pulse: got %0d want 1", n_ferr - f0); else n_pass++;
    n_checks++; if (n_valid - v0 !== 0) $display("FAIL ferr_valid: got %0d want 0", n_valid - v0); else n_pass++;
    n_checks++; if (rx_data !== 8'h11) $display("FAIL ferr_data_hold: got %h want 11", rx_data); else n_pass++;
    wait_ticks(40 * OS);
    n_checks++; if (n_ferr - f0 !== 1) $display("FAIL break_ferr: got %0d want 1", n_ferr - f0); else n_pass++;
    n_checks++; if (n_valid - v0 !== 0) $display("FAIL break_valid: got %0d want 0", n_valid - v0); else n_pass++;
    n_checks++; if (rx_busy !== 1'b0) $display("FAIL break_busy: got %b want 0", rx_busy); else n_pass++;
    rx_in = 1'b1;
    wait_ticks(2 * OS);
    send_frame(8'h6B, 1'b1);
    n_checks++; if (n_valid - v0 !== 1) $display("FAIL recover_valid: got %0d want 1", n_valid - v0); else n_pass++;
    n_checks++; if (rx_data !== 8'h6B) $display("FAIL recover_data: got %h want 6b", rx_data); else n_pass++;
    n_checks++; if (n_ferr - f0 !== 1) $display("FAIL recover_ferr: got %0d want 1", n_ferr - f0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [DB-1:0] got0, got1;
    rx_in = 1'b1;
    align_tick();
    rx_q.delete();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_ticks(8);
    got0 = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    got1 = (rx_q.size() > 1) ? rx_q[1] : 8'hxx;
    n_checks++; if (rx_q.size() !== 2) $display("FAIL b2b_count: got %0d want 2", rx_q.size()); else n_pass++;
    n_checks++; if (got0 !== 8'h00) $display("FAIL b2b_first: got %h want 00", got0); else n_pass++;
    n_checks++; if (got1 !== 8'hFF) $display("FAIL b2b_second: got %h want ff", got1); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int v0, f0;
    logic [7:0] d;
    d = 8'h5A;
    align_tick();
    v0 = n_valid; f0 = n_ferr;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    rx_in = d[3];
    wait_ticks(OS / 2);
    n_checks++; if (rx_busy !== 1'b1) $display("FAIL mid_busy: got %b want 1", rx_busy); else n_pass++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (rx_busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", rx_busy); else n_pass++;
    n_checks++; if (rx_data !== 8'h00) $display("FAIL mid_rst_data: got %h want 00", rx_data); else n_pass++;
    rst = 1'b0;
    rx_in = 1'b1;
    wait_ticks(2 * OS);
    n_checks++; if (n_valid - v0 !== 0) $display("FAIL mid_no_strobe: got %0d want 0", n_valid - v0); else n_pass++;
    send_frame(8'h81, 1'b1);
    n_checks++; if (n_valid - v0 !== 1) $display("FAIL mid_next_valid: got %0d want 1", n_valid - v0); else n_pass++;
    n_checks++; if (rx_data !== 8'h81) $display("FAIL mid_next_data: got %h want 81", rx_data); else n_pass++;
    n_checks++; if (n_ferr - f0 !== 0) $display("FAIL mid_ferr: got %0d want 0", n_ferr - f0); else n_pass++;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par_b);
    t0 = tick_num;
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    send_bit(par_b);
    send_bit(1'b1);
  endtask

  task automatic test_parity();
    int v0, f0, p0;
    rx_in = 1'b1;
    align_tick();
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    send_frame_par(8'h07, 1'b1);
    n_checks++; if (n_valid - v0 !== 1) $display("FAIL par_ok_valid: got %0d want 1", n_valid - v0); else n_pass++;
    n_checks++; if (rx_data !== 8'h07) $display("FAIL par_ok_data: got %h want 07", rx_data); else n_pass++;
    n_checks++; if (n_perr - p0 !== 0) $display("FAIL par_ok_perr: got %0d want 0", n_perr - p0); else n_pass++;
    send_frame_par(8'h07, 1'b0);
    n_checks++; if (n_perr - p0 !== 1) $display("FAIL par_bad_perr: got %0d want 1", n_perr - p0); else n_pass++;
    n_checks++; if (n_valid - v0 !== 1) $display("FAIL par_bad_valid: got %0d want 1", n_valid - v0); else n_pass++;
    n_checks++; if (n_ferr - f0 !== 0) $display("FAIL par_bad_ferr: got %0d want 0", n_ferr - f0); else n_pass++;
    n_checks++; if (rx_data !== 8'h07) $display("FAIL par_bad_data: got %h want 07", rx_data); else n_pass++;
  endtask
`endif

  task automatic test_strobe_exclusive();
    n_checks++; if (simul !== 1'b0) $display("FAIL strobe_overlap: got %b want 0", simul); else n_pass++;
`ifndef UART_RX_PARITY_EN
    n_checks++; if (n_perr !== 0) $display("FAIL perr_tied_off: got %0d want 0", n_perr); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_glitch();
    test_frame_err_break();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_strobe_exclusive();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
